// File: rtl/axil_uart_master_burst_if.sv
// AXI4-Lite master/slave bundle used by axil_uart_master_burst.
// Every channel follows strict valid/ready semantics: a transfer happens on the
// rising edge where valid and ready are both high; once valid is raised, it and
// its payload hold until that edge, while ready may change freely.
interface axil_uart_master_burst_if #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0]   awaddr;
   logic                        awvalid;
   logic                        awready;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [AXI_ADDR_WIDTH-1:0]   araddr;
   logic                        arvalid;
   logic                        arready;
   logic [AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rvalid;
   logic                        rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_uart_master_burst.sv
// UART (8N1) command parser driving an AXI4-Lite master, burst of 1..MAX_COUNT words.
// Define AXIL_UART_TIMEOUT_EN to add the AXI handshake watchdog.
module axil_uart_master_burst #(
   parameter int       CLOCK           = 100_000_000,
   parameter int       BAUD_RATE       = 115_200,
   parameter int       AXI_DATA_WIDTH  = 32,
   parameter int       AXI_ADDR_WIDTH  = 32,
   parameter int       MAX_COUNT       = 16,
   parameter bit [7:0] UART_BYTE_START = 8'hF0,
   parameter bit [7:0] UART_BYTE_WR    = 8'hA1,
   parameter bit [7:0] UART_BYTE_RD    = 8'hA2,
   parameter bit [7:0] UART_BYTE_ERR   = 8'hEE,
   parameter int       TIMEOUT_CYCLES  = 1024
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      uart_rx,
   output logic                      uart_tx,
   axil_uart_master_burst_if.master  m_axil,
   output logic [3:0]                state_dbg
);
   localparam int NB       = AXI_DATA_WIDTH / 8;
   localparam int NA       = AXI_ADDR_WIDTH / 8;
   localparam int BIT_CYC  = CLOCK / BAUD_RATE;
   localparam int HALF_CYC = BIT_CYC / 2;

   typedef enum logic [3:0] {
      IDLE, CMD, COUNT, ADDR, WDATA, AXI_WR, AXI_RD, TX_RESP, TX_ERR
   } state_t;

   state_t state, state_next;

   logic       rx_s1, rx_s2, rx_prev, rx_active, rx_valid, rx_ferr;
   logic [3:0] rx_bit;
   logic [31:0] rx_cnt;
   logic [7:0] rx_sh, rx_byte;

   logic       tx_busy, tx_start;
   logic [7:0] tx_data;
   logic [8:0] tx_sh;
   logic [3:0] tx_bit;
   logic [31:0] tx_cnt;

   logic [7:0]                cmd_q, words_left;
   logic [3:0]                byte_idx;
   logic [AXI_ADDR_WIDTH-1:0] addr;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [1:0]                resp_q;
   logic                      timed_out, aw_done, w_done, ar_done;
   logic                      wr_done, rd_done, tmo, wd_hit, cmd_wr, resp_last;

   // Receiver: start confirmed at half-bit, then one sample per bit period.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_active <= 1'b0;
         rx_bit    <= '0;
         rx_cnt    <= '0;
         rx_sh     <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         rx_ferr   <= 1'b0;
      end else begin
         rx_s1    <= uart_rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (!rx_active) begin
            if (rx_prev && !rx_s2) begin
               rx_active <= 1'b1;
               rx_bit    <= '0;
               rx_cnt    <= 32'(HALF_CYC - 1);
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 32'd1;
         end else begin
            rx_cnt <= 32'(BIT_CYC - 1);
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               if (rx_s2) rx_active <= 1'b0;
            end else if (rx_bit == 4'd9) begin
               rx_active <= 1'b0;
               if (rx_s2) begin
                  rx_valid <= 1'b1;
                  rx_byte  <= rx_sh;
               end else begin
                  rx_ferr <= 1'b1;
               end
            end else begin
               rx_sh <= {rx_s2, rx_sh[7:1]};
            end
         end
      end
   end

   // Transmitter: uart_tx is registered so the line never glitches.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tx_busy <= 1'b0;
         uart_tx <= 1'b1;
         tx_sh   <= '0;
         tx_bit  <= '0;
         tx_cnt  <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            uart_tx <= 1'b0;
            tx_sh   <= {1'b1, tx_data};
            tx_bit  <= '0;
            tx_cnt  <= 32'(BIT_CYC - 1);
         end
      end else if (tx_cnt != '0) begin
         tx_cnt <= tx_cnt - 32'd1;
      end else begin
         tx_cnt <= 32'(BIT_CYC - 1);
         if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            uart_tx <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            tx_bit  <= tx_bit + 4'd1;
         end
      end
   end

`ifdef AXIL_UART_TIMEOUT_EN
   logic [31:0] wd_cnt;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                              wd_cnt <= '0;
      else if (state == AXI_WR || state == AXI_RD) wd_cnt <= wd_cnt + 32'd1;
      else                                       wd_cnt <= '0;
   end

   assign wd_hit = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign wd_hit = 1'b0;
`endif

   assign cmd_wr    = (cmd_q == UART_BYTE_WR);
   assign state_dbg = state;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_next;
   end

   // Bus valids/readies are decoded from registered state so reset clears them at once.
   always_comb begin
      state_next     = state;
      m_axil.awvalid = 1'b0;
      m_axil.wvalid  = 1'b0;
      m_axil.wstrb   = '0;
      m_axil.bready  = 1'b0;
      m_axil.arvalid = 1'b0;
      m_axil.rready  = 1'b0;
      tx_start       = 1'b0;
      tx_data        = 8'h00;
      wr_done        = 1'b0;
      rd_done        = 1'b0;
      tmo            = 1'b0;
      resp_last      = cmd_wr ? (byte_idx == 4'd0) : (byte_idx == 4'(NB));
      case (state)
         IDLE: if (rx_valid && rx_byte == UART_BYTE_START) state_next = CMD;
         CMD: begin
            if (rx_ferr)       state_next = IDLE;
            else if (rx_valid) state_next = COUNT;
         end
         COUNT: begin
            if (rx_ferr) begin
               state_next = IDLE;
            end else if (rx_valid) begin
               if ((cmd_q != UART_BYTE_WR && cmd_q != UART_BYTE_RD) ||
                   rx_byte == 8'd0 || int'(rx_byte) > MAX_COUNT)
                  state_next = TX_ERR;
               else
                  state_next = ADDR;
            end
         end
         ADDR: begin
            if (rx_ferr)
               state_next = IDLE;
            else if (rx_valid && byte_idx == 4'(NA - 1))
               state_next = cmd_wr ? WDATA : AXI_RD;
         end
         WDATA: begin
            if (rx_ferr)
               state_next = IDLE;
            else if (rx_valid && byte_idx == 4'(NB - 1))
               state_next = AXI_WR;
         end
         AXI_WR: begin
            m_axil.awvalid = !aw_done;
            m_axil.wvalid  = !w_done;
            m_axil.wstrb   = '1;
            m_axil.bready  = aw_done && w_done;
            wr_done        = m_axil.bready && m_axil.bvalid;
            tmo            = wd_hit && !wr_done;
            if (wr_done || tmo) state_next = TX_RESP;
         end
         AXI_RD: begin
            m_axil.arvalid = !ar_done;
            m_axil.rready  = 1'b1;
            rd_done        = m_axil.rvalid;
            tmo            = wd_hit && !rd_done;
            if (rd_done || tmo) state_next = TX_RESP;
         end
         TX_RESP: begin
            tx_data = (byte_idx == 4'd0) ? {timed_out, 5'b0, resp_q}
                                         : rdata_q[AXI_DATA_WIDTH-1 -: 8];
            if (!tx_busy) begin
               tx_start = 1'b1;
               if (resp_last) begin
                  if (words_left == 8'd1) state_next = IDLE;
                  else                    state_next = cmd_wr ? WDATA : AXI_RD;
               end
            end
         end
         TX_ERR: begin
            tx_data = UART_BYTE_ERR;
            if (!tx_busy) begin
               tx_start   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cmd_q      <= '0;
         words_left <= '0;
         byte_idx   <= '0;
         addr       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         resp_q     <= '0;
         timed_out  <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         ar_done    <= 1'b0;
      end else begin
         case (state)
            IDLE: byte_idx <= '0;
            CMD: if (rx_valid) cmd_q <= rx_byte;
            COUNT: begin
               if (rx_valid) begin
                  words_left <= rx_byte;
                  byte_idx   <= '0;
               end
            end
            ADDR: begin
               if (rx_valid) begin
                  addr     <= {addr[AXI_ADDR_WIDTH-9:0], rx_byte};
                  byte_idx <= (byte_idx == 4'(NA - 1)) ? 4'd0 : byte_idx + 4'd1;
               end
            end
            WDATA: begin
               if (rx_valid) begin
                  wdata_q  <= {wdata_q[AXI_DATA_WIDTH-9:0], rx_byte};
                  byte_idx <= (byte_idx == 4'(NB - 1)) ? 4'd0 : byte_idx + 4'd1;
               end
            end
            AXI_WR: begin
               if (m_axil.awvalid && m_axil.awready) aw_done <= 1'b1;
               if (m_axil.wvalid && m_axil.wready)   w_done  <= 1'b1;
               if (wr_done) begin
                  resp_q    <= m_axil.bresp;
                  timed_out <= 1'b0;
               end else if (tmo) begin
                  resp_q    <= 2'b10;
                  timed_out <= 1'b1;
               end
            end
            AXI_RD: begin
               if (m_axil.arvalid && m_axil.arready) ar_done <= 1'b1;
               if (rd_done) begin
                  rdata_q   <= m_axil.rdata;
                  resp_q    <= m_axil.rresp;
                  timed_out <= 1'b0;
               end else if (tmo) begin
                  rdata_q   <= '0;
                  resp_q    <= 2'b10;
                  timed_out <= 1'b1;
               end
            end
            TX_RESP: begin
               if (tx_start) begin
                  // Byte 0 is the status; read data bytes shift out MSB first after it.
                  if (byte_idx != 4'd0) rdata_q <= rdata_q << 8;
                  if (resp_last) begin
                     byte_idx   <= '0;
                     words_left <= words_left - 8'd1;
                     addr       <= addr + AXI_ADDR_WIDTH'(NB);
                  end else begin
                     byte_idx <= byte_idx + 4'd1;
                  end
               end
            end
            default: ;
         endcase
         if (state != AXI_WR && state != AXI_RD) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ar_done <= 1'b0;
         end
      end
   end

   assign m_axil.awaddr = addr;
   assign m_axil.araddr = addr;
   assign m_axil.wdata  = wdata_q;
endmodule

// File: tb/tb_axil_uart_master_burst.sv
// Directed bench for axil_uart_master_burst: UART host driver, AXI-Lite slave model,
// UART reply monitor and an expected-byte queue.
module tb_axil_uart_master_burst;
   localparam int BIT = 8;

   logic       aclk    = 1'b0;
   logic       aresetn = 1'b0;
   logic       uart_rx = 1'b1;
   logic       uart_tx;
   logic [3:0] state_dbg;

   axil_uart_master_burst_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bus ();

   axil_uart_master_burst #(
      .CLOCK(1_600_000), .BAUD_RATE(200_000), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32),
      .MAX_COUNT(16), .TIMEOUT_CYCLES(16)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .m_axil(bus.master), .state_dbg(state_dbg)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [31:0] aw_log[$], w_log[$], ws_log[$], ar_log[$];
   logic [1:0]  wr_resp_q[$];
   logic [33:0] rd_q[$];
   logic        hold_aw = 1'b0;
   logic        slave_clear = 1'b0;
   logic        aw_got, w_got, ar_got, b_pend, r_pend;
   logic [7:0]  mon_b;
   logic [33:0] rd_word;
   int          wait_n;

   // Reply monitor: decodes uart_tx using time offsets (bit = 80 time units).
   initial begin
      forever begin
         @(negedge uart_tx);
         #40;
         if (uart_tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               #80;
               mon_b[i] = uart_tx;
            end
            #80;
            got_q.push_back(mon_b);
         end
      end
   end

   // AXI-Lite slave: works on the falling edge, so anything it sees is what the next rising edge samples.
   initial begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid = 1'b0;  bus.bresp = 2'b00;
      bus.rvalid = 1'b0;  bus.rresp = 2'b00; bus.rdata = '0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
      forever begin
         @(negedge aclk);
         bus.awready = !hold_aw;
         bus.wready  = 1'b1;
         bus.arready = 1'b1;
         if (slave_clear) begin
            aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            bus.bvalid = 1'b0; bus.rvalid = 1'b0;
         end
         if (b_pend) begin bus.bvalid = 1'b0; b_pend = 1'b0; end
         if (!bus.bvalid && aw_got && w_got) begin
            bus.bvalid = 1'b1;
            bus.bresp  = (wr_resp_q.size() > 0) ? wr_resp_q.pop_front() : 2'b00;
            aw_got = 1'b0; w_got = 1'b0;
         end
         if (bus.bvalid && bus.bready) b_pend = 1'b1;
         if (bus.awvalid && bus.awready) begin aw_log.push_back(bus.awaddr); aw_got = 1'b1; end
         if (bus.wvalid && bus.wready) begin
            w_log.push_back(bus.wdata);
            ws_log.push_back({28'd0, bus.wstrb});
            w_got = 1'b1;
         end
         if (r_pend) begin bus.rvalid = 1'b0; r_pend = 1'b0; end
         if (!bus.rvalid && ar_got) begin
            rd_word    = (rd_q.size() > 0) ? rd_q.pop_front() : 34'd0;
            bus.rvalid = 1'b1;
            bus.rresp  = rd_word[33:32];
            bus.rdata  = rd_word[31:0];
            ar_got     = 1'b0;
         end
         if (bus.rvalid && bus.rready) r_pend = 1'b1;
         if (bus.arvalid && bus.arready) begin ar_log.push_back(bus.araddr); ar_got = 1'b1; end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] seen, input logic [63:0] want);
      total++;
      assert (seen === want) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, seen, want);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      @(negedge aclk);
      uart_rx = 1'b0;
      repeat (BIT) @(negedge aclk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT) @(negedge aclk);
      end
      uart_rx = stop_bit;
      repeat (BIT) @(negedge aclk);
      uart_rx = 1'b1;
      if (!stop_bit) repeat (BIT) @(negedge aclk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] cnt, input logic [31:0] a);
      send_byte(8'hF0);
      send_byte(cmd);
      send_byte(cnt);
      send_word(a);
   endtask

   task automatic expect_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
   endtask

   task automatic check_tx(input string tag);
      logic [7:0] want, seen;
      int n;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         n = 0;
         while (got_q.size() == 0 && n < 3000) begin
            @(posedge aclk);
            n++;
         end
         seen = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         check(tag, {56'd0, seen}, {56'd0, want});
      end
   endtask

   task automatic clear_logs();
      aw_log.delete(); w_log.delete(); ws_log.delete(); ar_log.delete(); got_q.delete();
   endtask

   task automatic pulse_slave_clear();
      slave_clear = 1'b1;
      repeat (2) @(negedge aclk);
      slave_clear = 1'b0;
   endtask

   initial begin
      // Reset values while aresetn is held low
      repeat (4) @(negedge aclk);
      check("rst_uart_tx", 64'(uart_tx), 64'd1);
      check("rst_awvalid", 64'(bus.awvalid), 64'd0);
      check("rst_wvalid", 64'(bus.wvalid), 64'd0);
      check("rst_bready", 64'(bus.bready), 64'd0);
      check("rst_arvalid", 64'(bus.arvalid), 64'd0);
      check("rst_rready", 64'(bus.rready), 64'd0);
      check("rst_awaddr", 64'(bus.awaddr), 64'd0);
      check("rst_araddr", 64'(bus.araddr), 64'd0);
      check("rst_wdata", 64'(bus.wdata), 64'd0);
      check("rst_wstrb", 64'(bus.wstrb), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      aresetn = 1'b1;
      repeat (4) @(negedge aclk);

      // Single write
      clear_logs();
      wr_resp_q.push_back(2'b00);
      send_hdr(8'hA1, 8'd1, 32'h0000_1000);
      send_word(32'hDEAD_BEEF);
      exp_q.push_back(8'h00);
      check_tx("wr1_tx");
      check("wr1_awaddr", 64'(qget(aw_log, 0)), 64'h1000);
      check("wr1_wdata", 64'(qget(w_log, 0)), 64'hDEAD_BEEF);
      check("wr1_wstrb", 64'(qget(ws_log, 0)), 64'hF);

      // Three-word read wrapping past the top of the address space
      clear_logs();
      rd_q.push_back({2'b00, 32'd1});
      rd_q.push_back({2'b00, 32'd2});
      rd_q.push_back({2'b00, 32'd3});
      send_hdr(8'hA2, 8'd3, 32'hFFFF_FFFC);
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(8'h00);
         expect_word(32'(k));
      end
      check_tx("rd3_tx");
      check("rd3_araddr0", 64'(qget(ar_log, 0)), 64'hFFFF_FFFC);
      check("rd3_araddr1", 64'(qget(ar_log, 1)), 64'h0);
      check("rd3_araddr2", 64'(qget(ar_log, 2)), 64'h4);

      // Bad command, zero count and count above MAX_COUNT
      clear_logs();
      send_byte(8'hF0); send_byte(8'hA5); send_byte(8'h01);
      exp_q.push_back(8'hEE);
      check_tx("err_cmd_tx");
      send_byte(8'hF0); send_byte(8'hA1); send_byte(8'h00);
      exp_q.push_back(8'hEE);
      check_tx("err_cnt0_tx");
      send_byte(8'hF0); send_byte(8'hA2); send_byte(8'd17);
      exp_q.push_back(8'hEE);
      check_tx("err_cnt17_tx");
      check("err_no_aw", 64'(aw_log.size()), 64'd0);
      check("err_no_ar", 64'(ar_log.size()), 64'd0);

      // Read with SLVERR on the second word: both words still returned
      clear_logs();
      rd_q.push_back({2'b00, 32'h1122_3344});
      rd_q.push_back({2'b10, 32'h5566_7788});
      send_hdr(8'hA2, 8'd2, 32'h0000_0020);
      exp_q.push_back(8'h00); expect_word(32'h1122_3344);
      exp_q.push_back(8'h02); expect_word(32'h5566_7788);
      check_tx("rd_slverr_tx");
      check("rd_slverr_araddr1", 64'(qget(ar_log, 1)), 64'h24);

      // Noise before START and a framing error mid-header, then a two-word write
      clear_logs();
      send_byte(8'h55);
      send_byte(8'hF0);
      send_byte(8'hA1);
      send_byte(8'h00, 1'b0);
      repeat (200) @(negedge aclk);
      check("ferr_no_reply", 64'(got_q.size()), 64'd0);
      wr_resp_q.push_back(2'b00);
      wr_resp_q.push_back(2'b10);
      send_hdr(8'hA1, 8'd2, 32'h0000_0040);
      send_word(32'h0102_0304);
      exp_q.push_back(8'h00);
      check_tx("wr2_status0");
      send_word(32'hA5A5_A5A5);
      exp_q.push_back(8'h02);
      check_tx("wr2_status1");
      check("wr2_awaddr0", 64'(qget(aw_log, 0)), 64'h40);
      check("wr2_awaddr1", 64'(qget(aw_log, 1)), 64'h44);
      check("wr2_wdata0", 64'(qget(w_log, 0)), 64'h0102_0304);
      check("wr2_wdata1", 64'(qget(w_log, 1)), 64'hA5A5_A5A5);

`ifdef AXIL_UART_TIMEOUT_EN
      // Watchdog: awready never rises, status carries the timeout bit and SLVERR
      clear_logs();
      hold_aw = 1'b1;
      send_hdr(8'hA1, 8'd1, 32'h0000_0080);
      send_word(32'h1234_5678);
      exp_q.push_back(8'h82);
      check_tx("tmo_tx");
      check("tmo_awvalid_low", 64'(bus.awvalid), 64'd0);
      check("tmo_no_aw", 64'(aw_log.size()), 64'd0);
      hold_aw = 1'b0;
      pulse_slave_clear();
`endif

      // Reset while a write sits in AXI_WR waiting for awready
      clear_logs();
      hold_aw = 1'b1;
      send_hdr(8'hA1, 8'd1, 32'h0000_0200);
      send_word(32'h1111_1111);
      wait_n = 0;
      while (bus.awvalid !== 1'b1 && wait_n < 2000) begin
         @(negedge aclk);
         wait_n++;
      end
      check("rstmid_awvalid_seen", 64'(bus.awvalid), 64'd1);
      repeat (3) @(negedge aclk);
      aresetn = 1'b0;
      #1;
      check("rstmid_awvalid", 64'(bus.awvalid), 64'd0);
      check("rstmid_bready", 64'(bus.bready), 64'd0);
      check("rstmid_uart_tx", 64'(uart_tx), 64'd1);
      check("rstmid_awaddr", 64'(bus.awaddr), 64'd0);
      check("rstmid_state", 64'(state_dbg), 64'd0);
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      hold_aw = 1'b0;
      pulse_slave_clear();
      repeat (300) @(negedge aclk);
      check("rstmid_no_reply", 64'(got_q.size()), 64'd0);

      // Next frame after reset is handled normally
      clear_logs();
      rd_q.push_back({2'b00, 32'hCAFE_F00D});
      send_hdr(8'hA2, 8'd1, 32'h0000_0100);
      exp_q.push_back(8'h00);
      expect_word(32'hCAFE_F00D);
      check_tx("post_rst_tx");
      check("post_rst_araddr", 64'(qget(ar_log, 0)), 64'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
